// File: rtl/dmem_pkg.sv
// Shared constants, request bundle and width decode for the data-memory arbiter.
// Purely declarative: no latency, no backpressure.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
    } mem_req_t;

    // Bytes touched by an access; unknown codes report 1 and are rejected elsewhere.
    function automatic logic [2:0] size_of(input logic [2:0] func3);
        case (func3)
            F3_H, F3_HU: size_of = 3'd2;
            F3_W:        size_of = 3'd4;
            default:     size_of = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality decode (func3, alignment, range) of one memory request.
// Latency: zero cycles; backpressure: none, pure function of its inputs.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [2:0] func3,
    output logic       legal
);

    localparam logic [9:0] DEPTH_W = 10'(DEPTH);

    logic       f3_ok;
    logic       align_ok;
    logic       range_ok;
    logic [9:0] last_byte;

    always_comb begin
        f3_ok = 1'b0;
        case (func3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !we;
            default:          f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b1;
        case (func3)
            F3_H, F3_HU: align_ok = !addr[0];
            F3_W:        align_ok = (addr[1:0] == 2'b00);
            default:     align_ok = 1'b1;
        endcase
    end

    // Widened so a word near 0xFF cannot wrap back into range.
    assign last_byte = {2'b00, addr} + {7'd0, size_of(func3)} - 10'd1;
    assign range_ok  = (last_byte < DEPTH_W);
    assign legal     = f3_ok && align_ok && range_ok;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core (C) and loader (L): round-robin, loader lock, starvation guard, legality check.
// Latency: gnt/strobes same cycle, rvalid/err/rdata next cycle; backpressure: requests held until gnt, one access per cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [7:0]  c_addr,
    input  logic [31:0] c_wdata,
    input  logic [2:0]  c_func3,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [7:0]  l_addr,
    input  logic [31:0] l_wdata,
    input  logic [2:0]  l_func3,
    input  logic        l_lock,
    output logic        c_gnt,
    output logic        l_gnt,
    output logic        c_rvalid,
    output logic        l_rvalid,
    output logic [31:0] c_rdata,
    output logic [31:0] l_rdata,
    output logic        c_err,
    output logic        l_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic          last;
    logic          locked;
    logic [WW-1:0] wait_cnt;

    logic          gnt_c;
    logic          gnt_l;
    logic          gnt_any;
    logic          legal;
    mem_req_t      c_bus;
    mem_req_t      l_bus;
    mem_req_t      req;

    logic          c_rvalid_q;
    logic          l_rvalid_q;
    logic          c_err_q;
    logic          l_err_q;
    logic [31:0]   c_rdata_q;
    logic [31:0]   l_rdata_q;

    assign c_bus = '{we: c_we, addr: c_addr, wdata: c_wdata, func3: c_func3};
    assign l_bus = '{we: l_we, addr: l_addr, wdata: l_wdata, func3: l_func3};

    always_comb begin
        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (rst_n) begin
            if (c_req && l_req) begin
                // A held lock beats round-robin until the core has waited MAX_WAIT cycles.
                if (locked) begin
                    gnt_l = (wait_cnt != WAIT_MAX);
                    gnt_c = (wait_cnt == WAIT_MAX);
                end else if (last == PORT_L) begin
                    gnt_c = 1'b1;
                end else begin
                    gnt_l = 1'b1;
                end
            end else begin
                gnt_c = c_req;
                gnt_l = l_req;
            end
        end
    end

    assign gnt_any = gnt_c || gnt_l;

    always_comb begin
        req = '0;
        if (gnt_l) begin
            req = l_bus;
        end else if (gnt_c) begin
            req = c_bus;
        end
    end

    dmem_access_check #(
        .DEPTH (DEPTH)
    ) u_check (
        .we    (req.we),
        .addr  (req.addr),
        .func3 (req.func3),
        .legal (legal)
    );

    assign mem_read  = gnt_any && legal && !req.we;
    assign mem_write = gnt_any && legal && req.we;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;
    assign mem_func3 = req.func3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last       <= PORT_L;
            locked     <= 1'b0;
            wait_cnt   <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            if (gnt_any) begin
                last   <= gnt_l ? PORT_L : PORT_C;
                locked <= gnt_l && l_lock;
            end

            if (c_req && !gnt_c) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end

            c_rvalid_q <= gnt_c && legal && !c_we;
            l_rvalid_q <= gnt_l && legal && !l_we;
            c_err_q    <= gnt_c && !legal;
            l_err_q    <= gnt_l && !legal;
            if (gnt_c && legal && !c_we) begin
                c_rdata_q <= mem_rdata;
            end
            if (gnt_l && legal && !l_we) begin
                l_rdata_q <= mem_rdata;
            end
        end
    end

    // A response emerging into a reset cycle is dropped rather than delivered.
    assign c_rvalid = c_rvalid_q && rst_n;
    assign l_rvalid = l_rvalid_q && rst_n;
    assign c_err    = c_err_q && rst_n;
    assign l_err    = l_err_q && rst_n;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;
    assign c_gnt    = gnt_c;
    assign l_gnt    = gnt_l;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-byte memory behind it.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        c_req, c_we, l_req, l_we, l_lock;
    logic [7:0]  c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;
    logic [2:0]  c_func3, l_func3;
    logic        c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [0:63];
    bit          seeded;
    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    int          tests;
    int          fails;

    dmem_arbiter #(.DEPTH(64), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_func3(l_func3),
        .l_lock(l_lock),
        .c_gnt(c_gnt), .l_gnt(l_gnt), .c_rvalid(c_rvalid), .l_rvalid(l_rvalid),
        .c_rdata(c_rdata), .l_rdata(l_rdata), .c_err(c_err), .l_err(l_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: seeded once, then commits stores at the edge.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
            mem[0]  <= 8'd17; mem[1]  <= 8'h00; mem[2]  <= 8'h00; mem[3]  <= 8'h00;
            mem[5]  <= 8'h33;
            mem[8]  <= 8'h04; mem[9]  <= 8'h00; mem[10] <= 8'hFE; mem[11] <= 8'hCA;
            mem[12] <= 8'h44; mem[13] <= 8'h33; mem[14] <= 8'h22; mem[15] <= 8'h11;
            seeded  <= 1'b1;
        end else if (mem_write) begin
            case (mem_func3)
                F3_B: mem[mem_addr[5:0]] <= mem_wdata[7:0];
                F3_H: begin
                    mem[mem_addr[5:0]]        <= mem_wdata[7:0];
                    mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
                end
                F3_W: begin
                    mem[mem_addr[5:0]]        <= mem_wdata[7:0];
                    mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
                    mem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
                    mem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        b0 = mem[mem_addr[5:0]];
        b1 = mem[mem_addr[5:0] + 6'd1];
        b2 = mem[mem_addr[5:0] + 6'd2];
        b3 = mem[mem_addr[5:0] + 6'd3];
        mem_rdata = 32'h0;
        case (mem_func3)
            F3_B:  mem_rdata = {{24{b0[7]}}, b0};
            F3_H:  mem_rdata = {{16{b1[7]}}, b1, b0};
            F3_W:  mem_rdata = {b3, b2, b1, b0};
            F3_BU: mem_rdata = {24'h0, b0};
            F3_HU: mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = 32'h0;
        endcase
    end

    // Response monitor: records what the DUT delivers, just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (c_rvalid) obs_q.push_back(mk_rsp(PORT_C, 1'b0, c_rdata));
        if (c_err)    obs_q.push_back(mk_rsp(PORT_C, 1'b1, 32'h0));
        if (l_rvalid) obs_q.push_back(mk_rsp(PORT_L, 1'b0, l_rdata));
        if (l_err)    obs_q.push_back(mk_rsp(PORT_L, 1'b1, 32'h0));
    end

    function automatic rsp_t mk_rsp(input logic port, input logic err, input logic [31:0] data);
        mk_rsp = '{port: port, err: err, data: data};
    endfunction

    task automatic set_c(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_func3 = f3;
    endtask

    task automatic set_l(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        l_req = req; l_we = we; l_addr = addr; l_wdata = wdata; l_func3 = f3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_c(1'b1, 1'b0, 8'd0, 32'h0, F3_W);
        set_l(1'b1, 1'b1, 8'd4, 32'hDEAD_BEEF, F3_W);
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({c_gnt, l_gnt, mem_read, mem_write} !== 4'b0000) begin
            fails++; $display("FAIL reset_gnt_strobes: got %b expected 0000", {c_gnt, l_gnt, mem_read, mem_write});
        end
        tests++;
        if ({c_rvalid, l_rvalid, c_err, l_err} !== 4'b0000) begin
            fails++; $display("FAIL reset_rsp: got %b expected 0000", {c_rvalid, l_rvalid, c_err, l_err});
        end
        tests++;
        if (c_rdata !== 32'h0 || l_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got c=%h l=%h expected 0", c_rdata, l_rdata);
        end
        tests++;
        if ({mem_addr, mem_wdata, mem_func3} !== 43'h0) begin
            fails++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h f3=%b expected 0", mem_addr, mem_wdata, mem_func3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        @(negedge clk);
        #1;
        tests++;
        if (obs_q.size() != 0 || mem[4] !== 8'h04) begin
            fails++; $display("FAIL reset_quiet: got %0d responses, byte4=%h expected 0 responses, byte4=04", obs_q.size(), mem[4]);
        end
        obs_q.delete();
    endtask

    task automatic test_alternate();
        logic [3:0] seq = 4'b1010;
        @(negedge clk);
        set_c(1'b1, 1'b0, 8'd12, 32'h0, F3_W);
        set_l(1'b1, 1'b1, 8'd12, 32'hAABB_CCDD, F3_W);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (c_gnt !== !seq[i] || l_gnt !== seq[i]) begin
                fails++; $display("FAIL alt_gnt[%0d]: got c=%b l=%b expected c=%b l=%b", i, c_gnt, l_gnt, !seq[i], seq[i]);
            end
            tests++;
            if (seq[i]) begin
                if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'hAABB_CCDD) begin
                    fails++; $display("FAIL alt_store[%0d]: got wr=%b rd=%b wdata=%h expected 1 0 aabbccdd", i, mem_write, mem_read, mem_wdata);
                end
            end else begin
                if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'd12) begin
                    fails++; $display("FAIL alt_load[%0d]: got rd=%b wr=%b addr=%h expected 1 0 0c", i, mem_read, mem_write, mem_addr);
                end
                exp_q.push_back(mk_rsp(PORT_C, 1'b0, (i == 0) ? 32'h1122_3344 : 32'hAABB_CCDD));
            end
            @(negedge clk);
        end
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        #6;
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL alt_rsp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL alt_rsp[%0d]: got none expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL alt_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_core_load();
        @(negedge clk);
        set_c(1'b1, 1'b0, 8'd0, 32'h0, F3_W);
        #1;
        tests++;
        if (c_gnt !== 1'b1 || l_gnt !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 8'd0 || mem_func3 !== F3_W) begin
            fails++; $display("FAIL core_lw: got gnt=%b%b rd=%b addr=%h f3=%b expected 10 1 00 010", c_gnt, l_gnt, mem_read, mem_addr, mem_func3);
        end
        exp_q.push_back(mk_rsp(PORT_C, 1'b0, 32'd17));
        @(negedge clk);
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        #1;
        tests++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'd17) begin
            fails++; $display("FAIL core_rvalid: got rvalid=%b rdata=%h expected 1 00000011", c_rvalid, c_rdata);
        end
        tests++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, mem_func3} !== 45'h0) begin
            fails++; $display("FAIL idle_bus: got rd=%b wr=%b addr=%h wdata=%h f3=%b expected all 0", mem_read, mem_write, mem_addr, mem_wdata, mem_func3);
        end
        #5;
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL core_rsp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL core_rsp[%0d]: got none expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL core_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_lock_burst();
        logic [5:0] seq = 6'b101111;
        @(negedge clk);
        set_c(1'b1, 1'b0, 8'd8, 32'h0, F3_W);
        set_l(1'b1, 1'b0, 8'd0, 32'h0, F3_W);
        l_lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (c_gnt !== !seq[i] || l_gnt !== seq[i]) begin
                fails++; $display("FAIL lock_gnt[%0d]: got c=%b l=%b expected c=%b l=%b", i, c_gnt, l_gnt, !seq[i], seq[i]);
            end
            if (seq[i]) exp_q.push_back(mk_rsp(PORT_L, 1'b0, 32'd17));
            else        exp_q.push_back(mk_rsp(PORT_C, 1'b0, 32'hCAFE_0004));
            @(negedge clk);
        end
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        l_lock = 1'b0;
        #6;
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL lock_rsp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL lock_rsp[%0d]: got none expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL lock_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        logic [3:0]  t_port  = 4'b1010;
        logic [3:0]  t_we    = 4'b0110;
        logic [3:0]  t_legal = 4'b1000;
        logic [7:0]  t_addr [4];
        logic [2:0]  t_f3   [4];
        logic [31:0] t_data [4];
        t_addr = '{8'd2, 8'd63, 8'd0, 8'd63};
        t_f3   = '{F3_W, F3_H, F3_BU, F3_BU};
        t_data = '{32'h0, 32'h0000_BEEF, 32'h0000_0099, 32'h0};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (t_port[i]) begin
                set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
                set_l(1'b1, t_we[i], t_addr[i], t_data[i], t_f3[i]);
            end else begin
                set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
                set_c(1'b1, t_we[i], t_addr[i], t_data[i], t_f3[i]);
            end
            #1;
            tests++;
            if (c_gnt !== !t_port[i] || l_gnt !== t_port[i]) begin
                fails++; $display("FAIL illegal_gnt[%0d]: got c=%b l=%b expected c=%b l=%b", i, c_gnt, l_gnt, !t_port[i], t_port[i]);
            end
            tests++;
            if (mem_read !== (t_legal[i] && !t_we[i]) || mem_write !== 1'b0) begin
                fails++; $display("FAIL illegal_strobe[%0d]: got rd=%b wr=%b expected rd=%b wr=0", i, mem_read, mem_write, t_legal[i] && !t_we[i]);
            end
            exp_q.push_back(mk_rsp(t_port[i], !t_legal[i], t_legal[i] ? 32'h0000_003F : 32'h0));
            @(negedge clk);
        end
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        #6;
        tests++;
        if (c_rdata !== 32'hCAFE_0004 || l_rdata !== 32'h0000_003F) begin
            fails++; $display("FAIL illegal_rdata_hold: got c=%h l=%h expected cafe0004 0000003f", c_rdata, l_rdata);
        end
        tests++;
        if (mem[63] !== 8'h3F || mem[0] !== 8'd17) begin
            fails++; $display("FAIL illegal_no_write: got byte63=%h byte0=%h expected 3f 11", mem[63], mem[0]);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL illegal_rsp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL illegal_rsp[%0d]: got none expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL illegal_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_write();
        @(negedge clk);
        set_c(1'b1, 1'b0, 8'd0, 32'h0, F3_W);
        @(negedge clk);
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        rst_n = 1'b0;
        set_l(1'b1, 1'b1, 8'd5, 32'h0000_005A, F3_B);
        #1;
        tests++;
        if (l_gnt !== 1'b0 || mem_write !== 1'b0 || c_rvalid !== 1'b0) begin
            fails++; $display("FAIL rst_store: got gnt=%b wr=%b c_rvalid=%b expected 0 0 0", l_gnt, mem_write, c_rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_c(1'b1, 1'b0, 8'd5, 32'h0, F3_BU);
        set_l(1'b1, 1'b0, 8'd5, 32'h0, F3_BU);
        #1;
        tests++;
        if (c_gnt !== 1'b1 || l_gnt !== 1'b0 || c_rdata !== 32'h0) begin
            fails++; $display("FAIL rst_first_tie: got c=%b l=%b c_rdata=%h expected 1 0 0", c_gnt, l_gnt, c_rdata);
        end
        exp_q.push_back(mk_rsp(PORT_C, 1'b0, 32'h0000_0033));
        @(negedge clk);
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        #1;
        tests++;
        if (l_gnt !== 1'b1 || c_gnt !== 1'b0) begin
            fails++; $display("FAIL rst_second: got c=%b l=%b expected 0 1", c_gnt, l_gnt);
        end
        exp_q.push_back(mk_rsp(PORT_L, 1'b0, 32'h0000_0033));
        @(negedge clk);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        #6;
        tests++;
        if (mem[5] !== 8'h33) begin
            fails++; $display("FAIL rst_byte5: got %h expected 33", mem[5]);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rst_rsp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL rst_rsp[%0d]: got none expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL rst_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        l_lock = 1'b0;
        set_c(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        set_l(1'b0, 1'b0, 8'd0, 32'h0, 3'd0);
        test_reset();
        test_alternate();
        test_core_load();
        test_lock_burst();
        test_illegal();
        test_reset_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port byte-addressed data memory between two requesters: the core load/store unit (port C) and the program loader/debug port (port L). Per-cycle round-robin arbitration, a loader bus lock for bursts with a starvation limit protecting the core, and access legality checks (alignment, range, func3) before any memory strobe. Sits between the core/loader and the data memory's `MemRead`/`MemWrite`/`addr`/`data_in`/`func3`/`data_out` interface.

## Interface
- `DEPTH`, 64: memory size in bytes; an access is legal only if every byte it touches lies below `DEPTH`.
- `MAX_WAIT`, 4: consecutive cycles the core may be blocked by a loader lock before it is forced a grant.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `c_req`, `l_req` in 1: access request, held until granted.
- `c_we`, `l_we` in 1: 1 = store, 0 = load.
- `c_addr`, `l_addr` in 8: byte address.
- `c_wdata`, `l_wdata` in 32: store data, LSB-aligned.
- `c_func3`, `l_func3` in 3: RV32 load/store width code.
- `l_lock` in 1: loader requests to keep the bus on its next request.
- `c_gnt`, `l_gnt` out 1: request accepted this cycle (combinational).
- `c_rvalid`, `l_rvalid` out 1: load data valid (registered pulse).
- `c_rdata`, `l_rdata` out 32: load data, held until the next load completes on that port.
- `c_err`, `l_err` out 1: illegal access response (registered pulse).
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_addr` out 8, `mem_wdata` out 32, `mem_func3` out 3: muxed request to memory.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- At most one grant per cycle; an access occurs in the cycle `req && gnt`.
- Arbitration: only one requester → it wins. Both → winner is the port not granted most recently (`last` register, reset = L, so C wins the first tie).
- Lock: if the previous grant went to L with `l_lock=1` and `l_req=1`, L wins regardless of `last`, unless `wait_cnt == MAX_WAIT`, in which case C wins.
- `wait_cnt`: increments, saturating at `MAX_WAIT`, each cycle `c_req && !c_gnt`. Clears on `c_gnt` or `!c_req`.
- Legality check on the granted request. Legal func3 for loads: 000, 001, 010, 100, 101; for stores: 000, 001, 010. Halfword requires `addr[0]=0`; word requires `addr[1:0]=0`. Range: `addr + size - 1 < DEPTH`.
- Legal load: `mem_read=1`, `mem_rdata` captured at the edge into that port's rdata, and rvalid pulses.
- Legal store: `mem_write=1`; the memory commits at the edge.
- Illegal access: still granted, consuming the slot and updating `last`. Both strobes stay 0 and err pulses next cycle. No rvalid, and rdata is unchanged.
- When nothing is granted: strobes are 0 and `mem_addr`/`mem_wdata`/`mem_func3` are 0.

## Timing
- Grant and memory strobes are combinational in the request cycle; rvalid/err/rdata appear one cycle later.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Reset values: all gnt, strobes, rvalid and err are 0; rdata = 0; `last` = L; `wait_cnt` = 0; lock state cleared.
- While `rst_n=0`, grants and strobes are forced 0 in that cycle, so no write can occur during reset. A response pending from the cycle before reset is discarded.
- Request withdrawn before grant: no effect. `wait_cnt` clears.

## Structure
- `dmem_pkg` holds:
  - func3 constants: `F3_B=000`, `F3_H=001`, `F3_W=010`, `F3_BU=100`, `F3_HU=101`.
  - port index constants `PORT_C=0`, `PORT_L=1`.
  - a `size_of(func3)` function.
- One sub-module, `dmem_access_check`: combinational legality decode (we, addr, func3 → legal), instantiated once on the muxed request.
- Arbiter state lives in the top: `last`, `locked`, `wait_cnt`, and the response registers.

## Test plan
- Reset, then C only: LW at addr 0 → `c_gnt` same cycle, `mem_read=1`; next cycle `c_rvalid=1` and `c_rdata=17`, given preload 17 at word 0.
- Both request every cycle: L stores, C loads → grants alternate C, L, C, L; `l_wdata=0xAABBCCDD` SW at 12, then C LW at 12 returns `0xAABBCCDD`.
- L locked burst (`l_lock=1`, continuous `l_req`) with C requesting, `MAX_WAIT=4` → L granted 4 cycles, C granted on cycle 5, then L resumes.
- Illegal accesses:
  - C LW at addr 2 → granted, `mem_read=0`, `c_err` pulse next cycle, `c_rvalid=0`.
  - L SH at addr 63 → `l_err`, no write.
  - C store with func3 100 → `c_err`.
- Drive `rst_n=0` in the same cycle as an L SB to addr 5 (value `0x5A`) → `mem_write=0`, and byte 5 is unchanged when read back after reset.
